// File: rtl/garage_pkg.sv
// rtl/garage_pkg.sv - lane state types and fee/BCD helpers for the garage lane controller
package garage_pkg;

  typedef enum logic [2:0] {
    E_IDLE,
    E_PRINT,
    E_WAIT_TAKE,
    E_GATE_OPEN,
    E_OOS
  } entry_state_t;

  typedef enum logic [2:0] {
    X_IDLE,
    X_READ,
    X_WAIT_PAY,
    X_GATE_OPEN,
    X_ERROR
  } exit_state_t;

  localparam int BCD_W = 8;

  // Free within the grace period, otherwise every started hour costs rate units, capped at fee_max.
  function automatic logic [7:0] fee_calc(input logic [31:0] minutes, input int grace,
                                          input int rate, input int fee_max);
    logic [39:0] hours;
    logic [47:0] fee;
    logic [7:0]  result;
    hours = (40'(minutes) + 40'd59) / 40'd60;
    fee   = 48'(hours) * 48'(rate);
    if (minutes <= 32'(grace)) begin
      result = 8'd0;
    end else if (fee > 48'(fee_max)) begin
      result = 8'(fee_max);
    end else begin
      result = fee[7:0];
    end
    return result;
  endfunction

  function automatic logic [BCD_W-1:0] to_bcd2(input logic [7:0] value);
    logic [7:0] v;
    v = (value > 8'd99) ? 8'd99 : value;
    return {4'(v / 8'd10), 4'(v % 8'd10)};
  endfunction

endpackage

// File: rtl/garage_lane_timer.sv
// rtl/garage_lane_timer.sv - per-lane cycle counter with a derived whole-second index
module garage_lane_timer #(
  parameter int CLK_PER_SEC = 100_000_000
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_clear,
  output logic [31:0] o_cycles,
  output logic [7:0]  o_sec
);

  logic [31:0] r_cycles;
  logic [31:0] r_sub;
  logic [7:0]  r_sec;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_cycles <= '0;
      r_sub    <= '0;
      r_sec    <= '0;
    end else if (i_clear) begin
      r_cycles <= '0;
      r_sub    <= '0;
      r_sec    <= '0;
    end else begin
      if (r_cycles != '1) r_cycles <= r_cycles + 32'd1;
      if (r_sub == 32'(CLK_PER_SEC - 1)) begin
        r_sub <= '0;
        if (r_sec != '1) r_sec <= r_sec + 8'd1;
      end else begin
        r_sub <= r_sub + 32'd1;
      end
    end
  end

  assign o_cycles = r_cycles;
  assign o_sec    = r_sec;

endmodule

// File: rtl/garage_lane_ctrl.sv
// rtl/garage_lane_ctrl.sv - concurrent entry/exit lane FSMs with occupancy, fee and credit tracking
import garage_pkg::*;

module garage_lane_ctrl #(
  parameter int CAPACITY      = 64,
  parameter int DWIDTH        = 16,
  parameter int CLK_PER_SEC   = 100_000_000,
  parameter int TIMEOUT_SEC   = 5,
  parameter int RATE_PER_HOUR = 2,
  parameter int GRACE_MIN     = 15,
  parameter int FEE_MAX       = 99
) (
  input  logic                          i_clk,
  input  logic                          i_reset,
  input  logic                          i_entry_sensor,
  input  logic                          i_exit_sensor,
  input  logic                          i_request_btn,
  input  logic                          i_ticket_removed,
  input  logic                          i_ticket_inserted,
  input  logic                          i_ticket_ok,
  input  logic                          i_paper_empty,
  input  logic                          i_bill_2,
  input  logic                          i_bill_4,
  input  logic                          i_attendant_clr,
  input  logic [DWIDTH-1:0]             i_parking_time_min,
  output logic                          o_printer_cmd,
  output logic                          o_take_ticket_lamp,
  output logic                          o_out_of_service_lamp,
  output logic                          o_full_lamp,
  output logic                          o_entry_gate,
  output logic                          o_exit_gate,
  output logic [BCD_W-1:0]              o_fee_display,
  output logic                          o_thank_you_lamp,
  output logic                          o_see_attendant_lamp,
  output logic [$clog2(CAPACITY+1)-1:0] o_occupancy
);

  localparam int                OCC_W        = $clog2(CAPACITY + 1);
  localparam logic [OCC_W-1:0]  OCC_MAX      = OCC_W'(CAPACITY);
  localparam logic [31:0]       TIMEOUT_LAST = 32'(TIMEOUT_SEC * CLK_PER_SEC - 1);

  entry_state_t     r_e_state, w_e_nxt;
  exit_state_t      r_x_state, w_x_nxt;
  logic [31:0]      w_e_cycles, w_unused_x_cycles;
  logic [7:0]       w_x_sec, w_unused_e_sec;
  logic             w_e_clr, w_x_clr;
  logic [OCC_W-1:0] r_occ;
  logic             w_inc, w_dec;

  logic             r_printer_cmd, r_take_lamp, r_oos_lamp, r_entry_gate;
  logic             r_exit_gate, r_attendant_lamp;
  logic [BCD_W-1:0] r_fee_disp;
  logic [7:0]       r_fee, r_credit;
  logic [7:0]       w_fee_calc, w_fee_nxt, w_credit_add, w_credit_nxt, w_remain;
  logic [8:0]       w_credit_sum;

  assign w_e_clr = (w_e_nxt != r_e_state);
  assign w_x_clr = (w_x_nxt != r_x_state);

  garage_lane_timer #(.CLK_PER_SEC(CLK_PER_SEC)) u_entry_timer (
    .i_clk    (i_clk),
    .i_reset  (i_reset),
    .i_clear  (w_e_clr),
    .o_cycles (w_e_cycles),
    .o_sec    (w_unused_e_sec)
  );

  garage_lane_timer #(.CLK_PER_SEC(CLK_PER_SEC)) u_exit_timer (
    .i_clk    (i_clk),
    .i_reset  (i_reset),
    .i_clear  (w_x_clr),
    .o_cycles (w_unused_x_cycles),
    .o_sec    (w_x_sec)
  );

  // Entry lane; the timeout fires on the last cycle so the lamp is lit for exactly the allowed time.
  always_comb begin
    w_e_nxt = r_e_state;
    case (r_e_state)
      E_IDLE: begin
        if (i_paper_empty) w_e_nxt = E_OOS;
        else if (i_entry_sensor && i_request_btn && (r_occ < OCC_MAX)) w_e_nxt = E_PRINT;
      end
      E_PRINT:     w_e_nxt = E_WAIT_TAKE;
      E_WAIT_TAKE: begin
        if (i_ticket_removed) w_e_nxt = E_GATE_OPEN;
        else if (w_e_cycles == TIMEOUT_LAST) w_e_nxt = E_IDLE;
      end
      E_GATE_OPEN: if (!i_entry_sensor) w_e_nxt = E_IDLE;
      E_OOS:       if (!i_paper_empty) w_e_nxt = E_IDLE;
      default:     w_e_nxt = E_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_e_state     <= E_IDLE;
      r_printer_cmd <= 1'b0;
      r_take_lamp   <= 1'b0;
      r_oos_lamp    <= 1'b0;
      r_entry_gate  <= 1'b0;
    end else begin
      r_e_state     <= w_e_nxt;
      r_printer_cmd <= (w_e_nxt == E_PRINT);
      r_take_lamp   <= (w_e_nxt == E_WAIT_TAKE);
      r_oos_lamp    <= (w_e_nxt == E_OOS);
      r_entry_gate  <= (w_e_nxt == E_GATE_OPEN);
    end
  end

  assign w_fee_calc   = fee_calc(32'(i_parking_time_min), GRACE_MIN, RATE_PER_HOUR, FEE_MAX);
  assign w_credit_sum = {1'b0, r_credit} + (i_bill_2 ? 9'd2 : 9'd0) + (i_bill_4 ? 9'd4 : 9'd0);
  assign w_credit_add = w_credit_sum[8] ? 8'hFF : w_credit_sum[7:0];
  assign w_fee_nxt    = (r_x_state == X_READ && i_ticket_ok) ? w_fee_calc : r_fee;
  assign w_credit_nxt = (r_x_state == X_WAIT_PAY) ? w_credit_add : r_credit;
  assign w_remain     = (w_fee_nxt > w_credit_nxt) ? (w_fee_nxt - w_credit_nxt) : 8'd0;

  always_comb begin
    w_x_nxt = r_x_state;
    case (r_x_state)
      X_IDLE: if (i_exit_sensor && i_ticket_inserted && (r_occ != '0)) w_x_nxt = X_READ;
      X_READ: begin
        if (!i_ticket_ok) w_x_nxt = X_ERROR;
        else if (w_fee_calc == 8'd0) w_x_nxt = X_GATE_OPEN;
        else w_x_nxt = X_WAIT_PAY;
      end
      X_WAIT_PAY: begin
        if (!i_exit_sensor) w_x_nxt = X_IDLE;
        else if (r_credit >= r_fee) w_x_nxt = X_GATE_OPEN;
      end
      X_GATE_OPEN: if (!i_exit_sensor) w_x_nxt = X_IDLE;
      X_ERROR:     if (i_attendant_clr) w_x_nxt = X_IDLE;
      default:     w_x_nxt = X_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_x_state        <= X_IDLE;
      r_fee            <= '0;
      r_credit         <= '0;
      r_fee_disp       <= '0;
      r_exit_gate      <= 1'b0;
      r_attendant_lamp <= 1'b0;
    end else begin
      r_x_state <= w_x_nxt;
      if (w_x_nxt == X_IDLE) begin
        r_fee    <= '0;
        r_credit <= '0;
      end else begin
        r_fee    <= w_fee_nxt;
        r_credit <= w_credit_nxt;
      end
      r_fee_disp       <= (w_x_nxt == X_WAIT_PAY) ? to_bcd2(w_remain) : '0;
      r_exit_gate      <= (w_x_nxt == X_GATE_OPEN);
      r_attendant_lamp <= (w_x_nxt == X_ERROR);
    end
  end

  // A car passing each gate in the same cycle cancels out.
  assign w_inc = (r_e_state == E_GATE_OPEN) && !i_entry_sensor;
  assign w_dec = (r_x_state == X_GATE_OPEN) && !i_exit_sensor;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_occ <= '0;
    end else begin
      case ({w_inc, w_dec})
        2'b10:   if (r_occ != OCC_MAX) r_occ <= r_occ + 1'b1;
        2'b01:   if (r_occ != '0) r_occ <= r_occ - 1'b1;
        default: r_occ <= r_occ;
      endcase
    end
  end

  assign o_printer_cmd         = r_printer_cmd;
  assign o_take_ticket_lamp    = r_take_lamp;
  assign o_out_of_service_lamp = r_oos_lamp;
  assign o_entry_gate          = r_entry_gate;
  assign o_exit_gate           = r_exit_gate;
  assign o_see_attendant_lamp  = r_attendant_lamp;
  assign o_fee_display         = r_fee_disp;
  assign o_occupancy           = r_occ;
  assign o_full_lamp           = (r_occ == OCC_MAX);
  assign o_thank_you_lamp      = (r_x_state == X_GATE_OPEN) && (w_x_sec == 8'd0 || w_x_sec == 8'd2);

endmodule

// File: tb/tb_garage_lane_ctrl.sv
// tb/tb_garage_lane_ctrl.sv - randomized self-checking bench for garage_lane_ctrl
module tb_garage_lane_ctrl;

  localparam int CAP = 2, DW = 16, CPS = 10, TO_SEC = 5, RATE = 2, GRACE = 15, FMAX = 99;

  logic          i_clk = 1'b0, i_reset = 1'b1;
  logic          i_entry_sensor = 0, i_exit_sensor = 0, i_request_btn = 0, i_ticket_removed = 0;
  logic          i_ticket_inserted = 0, i_ticket_ok = 0, i_paper_empty = 0;
  logic          i_bill_2 = 0, i_bill_4 = 0, i_attendant_clr = 0;
  logic [DW-1:0] i_parking_time_min = '0;
  logic          o_printer_cmd, o_take_ticket_lamp, o_out_of_service_lamp, o_full_lamp;
  logic          o_entry_gate, o_exit_gate, o_thank_you_lamp, o_see_attendant_lamp;
  logic [7:0]    o_fee_display;
  logic [1:0]    o_occupancy;

  int n_chk = 0, n_err = 0, m_occ = 0;
  int minute_tbl[12] = '{0, 15, 16, 59, 60, 61, 120, 121, 1500, 2999, 3000, 65535};

  garage_lane_ctrl #(.CAPACITY(CAP), .DWIDTH(DW), .CLK_PER_SEC(CPS), .TIMEOUT_SEC(TO_SEC),
                     .RATE_PER_HOUR(RATE), .GRACE_MIN(GRACE), .FEE_MAX(FMAX)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_entry_sensor(i_entry_sensor), .i_exit_sensor(i_exit_sensor),
    .i_request_btn(i_request_btn), .i_ticket_removed(i_ticket_removed),
    .i_ticket_inserted(i_ticket_inserted), .i_ticket_ok(i_ticket_ok), .i_paper_empty(i_paper_empty),
    .i_bill_2(i_bill_2), .i_bill_4(i_bill_4), .i_attendant_clr(i_attendant_clr),
    .i_parking_time_min(i_parking_time_min), .o_printer_cmd(o_printer_cmd),
    .o_take_ticket_lamp(o_take_ticket_lamp), .o_out_of_service_lamp(o_out_of_service_lamp),
    .o_full_lamp(o_full_lamp), .o_entry_gate(o_entry_gate), .o_exit_gate(o_exit_gate),
    .o_fee_display(o_fee_display), .o_thank_you_lamp(o_thank_you_lamp),
    .o_see_attendant_lamp(o_see_attendant_lamp), .o_occupancy(o_occupancy)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int fee_model(input int minutes);
    int hours, fee;
    if (minutes <= GRACE) return 0;
    hours = minutes / 60 + ((minutes % 60 != 0) ? 1 : 0);
    fee = hours * RATE;
    return (fee > FMAX) ? FMAX : fee;
  endfunction

  function automatic int bcd(input int v);
    return (v / 10) * 16 + (v % 10);
  endfunction

  function automatic int pick_minutes();
    if ($urandom_range(0, 1) == 1) return minute_tbl[$urandom_range(0, 11)];
    return int'($urandom_range(0, 65535));
  endfunction

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic open_entry_gate();
    i_entry_sensor = 1; i_request_btn = 1;
    tick(); i_request_btn = 0;
    tick(); i_ticket_removed = 1;
    tick(); i_ticket_removed = 0;
  endtask

  task automatic entry_car(input int take_at, input int hold);
    int lamp, gate;
    lamp = 0; gate = 0;
    i_entry_sensor = 1; i_request_btn = 1;
    tick(); i_request_btn = 0;
    check("printer_pulse", o_printer_cmd, 1);
    tick();
    check("printer_single", o_printer_cmd, 0);
    for (int c = 0; c < take_at; c++) begin
      lamp += int'(o_take_ticket_lamp);
      tick();
    end
    lamp += int'(o_take_ticket_lamp);
    i_ticket_removed = 1;
    tick(); i_ticket_removed = 0;
    check("take_lamp_cycles", lamp, take_at + 1);
    for (int c = 0; c < hold; c++) begin
      gate += int'(o_entry_gate);
      if (c == hold - 1) i_entry_sensor = 0;
      tick();
    end
    m_occ++;
    check("entry_gate_cycles", gate, hold);
    check("entry_gate_closed", o_entry_gate, 0);
    check("occ_after_entry", o_occupancy, m_occ);
    check("full_lamp", o_full_lamp, m_occ == CAP);
  endtask

  task automatic exit_car(input int minutes, input int hold);
    int fee, credit, r, guard, gates;
    logic [63:0] obs_mask, exp_mask;
    fee = fee_model(minutes);
    i_exit_sensor = 1; i_ticket_inserted = 1; i_parking_time_min = 16'(minutes);
    tick(); i_ticket_inserted = 0; i_ticket_ok = 1;
    tick(); i_ticket_ok = 0;
    check("fee_display_initial", o_fee_display, bcd(fee));
    check("exit_gate_after_read", o_exit_gate, fee == 0);
    credit = 0; guard = 0;
    while (credit < fee && guard < 200) begin
      r = int'($urandom_range(0, 3));
      i_bill_2 = r[0]; i_bill_4 = r[1];
      tick();
      i_bill_2 = 0; i_bill_4 = 0;
      credit += 2 * (r & 1) + 4 * ((r >> 1) & 1);
      if (credit > 255) credit = 255;
      check("fee_display_after_bill", o_fee_display, bcd((credit >= fee) ? 0 : fee - credit));
      check("exit_gate_while_owed", o_exit_gate, 0);
      guard++;
    end
    check("pay_loop_bound", guard < 200, 1);
    if (fee != 0) tick();
    obs_mask = '0; exp_mask = '0; gates = 0;
    for (int c = 0; c < hold; c++) begin
      obs_mask[c] = o_thank_you_lamp;
      exp_mask[c] = (c / CPS == 0) || (c / CPS == 2);
      gates += int'(o_exit_gate);
      if (o_fee_display != 8'h00) check("fee_display_in_gate", o_fee_display, 0);
      if (c == hold - 1) i_exit_sensor = 0;
      tick();
    end
    m_occ--;
    check("thank_you_pattern", obs_mask, exp_mask);
    check("exit_gate_cycles", gates, hold);
    check("exit_gate_closed", o_exit_gate, 0);
    check("occ_after_exit", o_occupancy, m_occ);
  endtask

  task automatic exit_error();
    int n, on;
    i_exit_sensor = 1; i_ticket_inserted = 1;
    tick(); i_ticket_inserted = 0; i_ticket_ok = 0;
    tick();
    n = int'($urandom_range(3, 12)); on = 0;
    for (int c = 0; c < n; c++) begin
      on += int'(o_see_attendant_lamp);
      tick();
    end
    check("attendant_lamp_steady", on, n);
    check("exit_gate_on_error", o_exit_gate, 0);
    i_attendant_clr = 1;
    tick(); i_attendant_clr = 0;
    check("attendant_lamp_cleared", o_see_attendant_lamp, 0);
    check("occ_after_error", o_occupancy, m_occ);
    i_exit_sensor = 0;
    tick();
  endtask

  task automatic exit_walkaway();
    int fee;
    fee = fee_model(int'($urandom_range(200, 500)));
    i_parking_time_min = 16'(200 + (fee / 2 - 4) * 60);
    fee = fee_model(int'(i_parking_time_min));
    i_exit_sensor = 1; i_ticket_inserted = 1;
    tick(); i_ticket_inserted = 0; i_ticket_ok = 1;
    tick(); i_ticket_ok = 0; i_bill_2 = 1;
    tick(); i_bill_2 = 0;
    check("walkaway_partial_display", o_fee_display, bcd(fee - 2));
    i_exit_sensor = 0;
    tick();
    check("walkaway_display_cleared", o_fee_display, 0);
    check("walkaway_gate_closed", o_exit_gate, 0);
    check("walkaway_occ", o_occupancy, m_occ);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int lamp, pulses;
    repeat (3) tick();
    check("reset_occ", o_occupancy, 0);
    check("reset_gates", {o_entry_gate, o_exit_gate}, 0);
    check("reset_lamps", {o_take_ticket_lamp, o_out_of_service_lamp, o_full_lamp,
                          o_thank_you_lamp, o_see_attendant_lamp, o_printer_cmd}, 0);
    check("reset_fee_display", o_fee_display, 0);
    i_reset = 0;
    tick();

    // no ticket taken: lamp lit for exactly the timeout, nobody enters
    i_entry_sensor = 1; i_request_btn = 1;
    tick(); i_request_btn = 0;
    tick();
    lamp = 0; pulses = 0;
    for (int c = 0; c < 100; c++) begin
      lamp += int'(o_take_ticket_lamp);
      pulses += int'(o_entry_gate);
      tick();
    end
    check("timeout_lamp_cycles", lamp, TO_SEC * CPS);
    check("timeout_no_gate", pulses, 0);
    check("timeout_occ", o_occupancy, 0);
    i_entry_sensor = 0;
    tick();

    // exit refused while the garage is empty
    i_exit_sensor = 1; i_ticket_inserted = 1; i_ticket_ok = 1; i_parking_time_min = 16'd10;
    repeat (3) tick();
    check("empty_exit_gate", o_exit_gate, 0);
    check("empty_exit_attendant", o_see_attendant_lamp, 0);
    i_exit_sensor = 0; i_ticket_inserted = 0; i_ticket_ok = 0;
    tick();

    entry_car(3, 5);
    exit_car(130, 35);
    entry_car(TO_SEC * CPS - 1, 1);
    exit_car(10, 12);
    entry_car(int'($urandom_range(0, 48)), int'($urandom_range(1, 8)));
    entry_car(int'($urandom_range(0, 48)), int'($urandom_range(1, 8)));

    // full: request ignored
    i_entry_sensor = 1; i_request_btn = 1; pulses = 0; lamp = 0;
    for (int c = 0; c < 5; c++) begin
      tick();
      pulses += int'(o_printer_cmd);
      lamp += int'(o_take_ticket_lamp);
    end
    check("full_no_print", pulses, 0);
    check("full_no_lamp", lamp, 0);
    i_entry_sensor = 0; i_request_btn = 0;
    tick();
    check("full_occ", o_occupancy, CAP);

    exit_car(65535, 40);
    exit_error();
    exit_walkaway();

    for (int k = 0; k < 8; k++) begin
      if (m_occ < CAP && (m_occ == 0 || $urandom_range(0, 1) == 1))
        entry_car(int'($urandom_range(0, 48)), int'($urandom_range(1, 8)));
      else
        exit_car(pick_minutes(), int'($urandom_range(5, 40)));
    end
    while (m_occ > 1) exit_car(10, 3);
    while (m_occ < 1) entry_car(2, 2);

    // both gates pass a car in the same cycle
    open_entry_gate();
    i_exit_sensor = 1; i_ticket_inserted = 1; i_parking_time_min = 16'd10;
    tick(); i_ticket_inserted = 0; i_ticket_ok = 1;
    tick(); i_ticket_ok = 0;
    check("simul_gates_open", {o_entry_gate, o_exit_gate}, 2'b11);
    i_entry_sensor = 0; i_exit_sensor = 0;
    tick();
    check("simul_occ", o_occupancy, m_occ);
    check("simul_gates_closed", {o_entry_gate, o_exit_gate}, 0);

    // printer out of paper
    i_paper_empty = 1;
    tick();
    check("oos_lamp_on", o_out_of_service_lamp, 1);
    i_entry_sensor = 1; i_request_btn = 1;
    tick(); tick();
    check("oos_no_print", {o_printer_cmd, o_take_ticket_lamp}, 0);
    i_entry_sensor = 0; i_request_btn = 0; i_paper_empty = 0;
    tick();
    check("oos_lamp_off", o_out_of_service_lamp, 0);

    // asynchronous reset while the entry gate is open
    open_entry_gate();
    check("gate_open_before_reset", o_entry_gate, 1);
    @(negedge i_clk);
    i_reset = 1;
    #1;
    check("reset_closes_gate", o_entry_gate, 0);
    check("reset_clears_occ", o_occupancy, 0);
    m_occ = 0;
    tick();
    i_reset = 0; i_entry_sensor = 0;
    tick();
    check("post_reset_occ", o_occupancy, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
